// File: rtl/dffsre_bank_pkg.sv
// Shared types and constants for the dffsre bank reader.
package dffsre_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PAR
    } state_e;

    localparam logic IDLE_LEVEL    = 1'b1;
    localparam int   DEFAULT_WIDTH = 10;

endpackage

// File: rtl/dffsre_bank_bitcnt.sv
// Beat counter for the bank reader: counts accepted data beats, flags the last one.
module dffsre_bank_bitcnt #(
    parameter int WIDTH = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == CW'(WIDTH - 1));

    // Saturates at the terminal value; the next capture clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !last) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dffsre_bank_reader.sv
// Captures the dffsre bank word and unloads it over a valid/ready serial stream.
// Optional even-parity trailer beat: define DFFSRE_BANK_READER_PARITY_EN.
module dffsre_bank_reader
    import dffsre_bank_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LSB_FIRST = 1
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic             start,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             done_q, done_d;
    logic             accept;
    logic             capture;
    logic             last_beat;
`ifdef DFFSRE_BANK_READER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign ser_valid = (state_q == ST_SHIFT) || (state_q == ST_PAR);
    assign busy      = ser_valid;
    assign done      = done_q;
    assign accept    = ser_valid && ser_ready && E;
    assign capture   = (state_q == ST_IDLE) && start && E;

    dffsre_bank_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk   (C),
        .rst_n (R),
        .en    (E),
        .clr   (capture),
        .inc   (accept && (state_q == ST_SHIFT)),
        .last  (last_beat)
    );

    always_comb begin
        ser_out = IDLE_LEVEL;
        case (state_q)
            ST_SHIFT: ser_out = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
`ifdef DFFSRE_BANK_READER_PARITY_EN
            ST_PAR:   ser_out = parity_q;
`endif
            default:  ser_out = IDLE_LEVEL;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        done_d   = 1'b0;
`ifdef DFFSRE_BANK_READER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d  = par_in;
                    state_d  = ST_SHIFT;
`ifdef DFFSRE_BANK_READER_PARITY_EN
                    parity_d = ^par_in;
`endif
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    if (LSB_FIRST != 0) begin
                        shreg_d = {IDLE_LEVEL, shreg_q[WIDTH-1:1]};
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], IDLE_LEVEL};
                    end
                    if (last_beat) begin
`ifdef DFFSRE_BANK_READER_PARITY_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef DFFSRE_BANK_READER_PARITY_EN
            ST_PAR: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge C) begin
        if (!R) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '1;
            done_q   <= 1'b0;
`ifdef DFFSRE_BANK_READER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (E) begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            done_q   <= done_d;
`ifdef DFFSRE_BANK_READER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
